ram_arb: RTL and testbench

- Two-port arbiter and sequencer in front of the 256x8 data RAM (async read, sync write).
- Shares the RAM between requester 0 (CPU data port) and requester 1 (loader/debug DMA).
- Registers the grant, drives the RAM address, write-data and write-enable for exactly one access cycle, captures read data, and acks the winner.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/ram_arb_if.sv | 56 +++++
 rtl/ram_arb_pick.sv | 44 ++++
 rtl/ram_arb.sv | 134 +++++++++++++
 tb/tb_ram_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-RAM arbiter slice.
//   AW_DEF / DW_DEF : default RAM address / data width (256 x 8)
//   state_t         : sequencer states (ST_IDLE, ST_ACCESS, ST_DONE)
//   REQ_CPU/REQ_DMA : requester index constants (0 = CPU data port, 1 = DMA)
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// ---------------------------------------------------------------------------
// ram_arb_if
// Bundles both requester ports and the RAM-side bus of the arbiter.
//   Requester N (N = 0,1): reqN, weN, addrN, wdataN in; ackN, rdataN out
//   RAM side: ram_abus, ram_dbus_i, ram_wr_en out; ram_dbus_o in (async read)
//   busy: arbiter is in an access or completion cycle
// Modports: slave = arbiter view, master = requester/RAM environment view.
//
// Handshake: reqN is a level. Once raised, weN/addrN/wdataN stay stable and
// reqN stays high until the one-cycle ackN pulse. From the cycle after ackN
// the requester either drops reqN or presents the next request. rdataN is
// valid in the ackN cycle and holds until the next read ack for that port.
// ---------------------------------------------------------------------------
interface ram_arb_if
   import mem_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          ack0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          ack1;
   logic [DW-1:0] rdata1;

   logic [AW-1:0] ram_abus;
   logic [DW-1:0] ram_dbus_i;
   logic [DW-1:0] ram_dbus_o;
   logic          ram_wr_en;
   logic          busy;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ram_dbus_o,
      output ack0, rdata0, ack1, rdata1,
      output ram_abus, ram_dbus_i, ram_wr_en, busy
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ram_dbus_o,
      input  ack0, rdata0, ack1, rdata1,
      input  ram_abus, ram_dbus_i, ram_wr_en, busy
   );

endinterface

// File: rtl/ram_arb_pick.sv
// ---------------------------------------------------------------------------
// ram_arb_pick
// Combinational 2-way picker.
//   i_req0, i_req1 : pending requests
//   i_last         : requester granted most recently
//   o_winner       : index of the requester to grant (meaningful only when
//                    at least one request is pending)
// Build option RAM_ARB_RR_EN: when defined, simultaneous requests alternate
// (the requester other than i_last wins); when undefined, requester 0 always
// wins and i_last is ignored.
// ---------------------------------------------------------------------------
module ram_arb_pick
   import mem_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_winner
);

`ifdef RAM_ARB_RR_EN
   always_comb begin
      o_winner = REQ_DMA;
      if (i_req0 && i_req1) begin
         o_winner = ~i_last;
      end else if (i_req0) begin
         o_winner = REQ_CPU;
      end
   end
`else
   // Fixed priority: the last-grant history is kept by the caller but has
   // no influence here.
   logic w_unused_last;
   assign w_unused_last = i_last;

   always_comb begin
      o_winner = REQ_DMA;
      if (i_req0 || !i_req1) begin
         o_winner = REQ_CPU;
      end
   end
`endif

endmodule

// File: rtl/ram_arb.sv
// ---------------------------------------------------------------------------
// ram_arb
// Arbiter/sequencer sharing a 256x8 async-read / sync-write data RAM between
// requester 0 (CPU data port) and requester 1 (loader/debug DMA).
//   clk, rst    : system clock; synchronous active-high reset
//   bus         : ram_arb_if.slave (requester ports + RAM bus + busy)
//   o_dbg_state : current sequencer state, for observation only
// Each access takes IDLE -> ACCESS -> DONE: the RAM is driven for exactly
// the ACCESS cycle, read data is captured at its closing edge, and the ack
// is pulsed in DONE. Build option RAM_ARB_RR_EN selects round-robin instead
// of fixed-priority arbitration (see ram_arb_pick).
// ---------------------------------------------------------------------------
module ram_arb
   import mem_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic    clk,
   input  logic    rst,
   ram_arb_if.slave bus,
   output state_t  o_dbg_state
);

   state_t        r_state;
   state_t        w_next;
   logic          r_gnt;
   logic          r_last;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   logic          w_winner;
   logic          w_any_req;
   logic          w_gnt_we;
   logic [AW-1:0] w_gnt_addr;
   logic [DW-1:0] w_gnt_wdata;

   ram_arb_pick u_pick (
      .i_req0   (bus.req0),
      .i_req1   (bus.req1),
      .i_last   (r_last),
      .o_winner (w_winner)
   );

   assign w_any_req = bus.req0 | bus.req1;

   // Address/data are not registered: the requester holds them until ack,
   // so muxing them by the registered grant keeps the RAM bus free of any
   // path from req.
   assign w_gnt_we    = (r_gnt == REQ_DMA) ? bus.we1    : bus.we0;
   assign w_gnt_addr  = (r_gnt == REQ_DMA) ? bus.addr1  : bus.addr0;
   assign w_gnt_wdata = (r_gnt == REQ_DMA) ? bus.wdata1 : bus.wdata0;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Grant, last-grant pointer and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt    <= REQ_CPU;
         r_last   <= REQ_DMA;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_gnt <= w_winner;
               end
            end
            ST_ACCESS: begin
               // Reads capture the async RAM output at the closing edge;
               // writes leave both read-data registers untouched.
               if (!w_gnt_we) begin
                  if (r_gnt == REQ_DMA) begin
                     r_rdata1 <= bus.ram_dbus_o;
                  end else begin
                     r_rdata0 <= bus.ram_dbus_o;
                  end
               end
            end
            ST_DONE: begin
               r_last <= r_gnt;
            end
            default: ;
         endcase
      end
   end

   // Next state and outputs
   always_comb begin
      w_next         = r_state;
      bus.ram_abus   = '0;
      bus.ram_dbus_i = '0;
      bus.ram_wr_en  = 1'b0;
      bus.ack0       = 1'b0;
      bus.ack1       = 1'b0;
      bus.busy       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            bus.busy       = 1'b1;
            bus.ram_abus   = w_gnt_addr;
            bus.ram_dbus_i = w_gnt_wdata;
            bus.ram_wr_en  = w_gnt_we;
            w_next         = ST_DONE;
         end
         ST_DONE: begin
            bus.busy = 1'b1;
            bus.ack0 = (r_gnt == REQ_CPU);
            bus.ack1 = (r_gnt == REQ_DMA);
            w_next   = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign bus.rdata0  = r_rdata0;
   assign bus.rdata1  = r_rdata1;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_arb.sv
// ---------------------------------------------------------------------------
// tb_ram_arb
// Bench for ram_arb: drives both requesters, provides a 256x8 RAM (zero
// initialised), and checks every cycle against a transaction-timeline model,
// plus literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_ram_arb;
   import mem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arb_if #(.AW(8), .DW(8)) bus ();
   state_t dbg_state;

   ram_arb #(.AW(8), .DW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // Requester drive registers
   logic       req_r  [2];
   logic       we_r   [2];
   logic [7:0] addr_r [2];
   logic [7:0] wd_r   [2];

   assign bus.req0   = req_r[0];
   assign bus.we0    = we_r[0];
   assign bus.addr0  = addr_r[0];
   assign bus.wdata0 = wd_r[0];
   assign bus.req1   = req_r[1];
   assign bus.we1    = we_r[1];
   assign bus.addr1  = addr_r[1];
   assign bus.wdata1 = wd_r[1];

   // RAM: async read, sync write, no reset
   logic [7:0] ram [256];
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
   end
   always @(posedge clk) begin
      if (bus.ram_wr_en) ram[bus.ram_abus] <= bus.ram_dbus_i;
   end
   assign bus.ram_dbus_o = ram[bus.ram_abus];

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int ack_who[$];
   int ack_at[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // Each accepted request is a transaction with an access cycle and an ack
   // cycle on an absolute cycle timeline.
   int         cyc   = 0;
   int         m_acc = -1;
   int         m_ack = -1;
   int         m_who = 0;
   int         m_last = 1;
   logic       m_we  = 1'b0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_wd   = 8'h00;
   logic [7:0] m_mem [256];
   logic [7:0] m_rd  [2];
   bit         in_acc;
   bit         in_done;
   int         w;

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
   end

   function automatic int pick_model(bit r0, bit r1, int last);
`ifdef RAM_ARB_RR_EN
      if (r0 && r1) return (last == 0) ? 1 : 0;
`endif
      return r0 ? 0 : 1;
   endfunction

   always @(negedge clk) begin
      in_acc  = (cyc == m_acc);
      in_done = (cyc == m_ack);
      chk("cyc_ack0",   bus.ack0,      32'(in_done && m_who == 0));
      chk("cyc_ack1",   bus.ack1,      32'(in_done && m_who == 1));
      chk("cyc_busy",   bus.busy,      32'(in_acc || in_done));
      chk("cyc_wr_en",  bus.ram_wr_en, 32'(in_acc && m_we));
      chk("cyc_abus",   bus.ram_abus,  in_acc ? 32'(m_addr) : 32'h0);
      chk("cyc_dbus_i", bus.ram_dbus_i, (in_acc && m_we) ? 32'(m_wd) : (in_acc ? 32'(m_wd) : 32'h0));
      chk("cyc_rdata0", bus.rdata0,    32'(m_rd[0]));
      chk("cyc_rdata1", bus.rdata1,    32'(m_rd[1]));
      chk("cyc_state",  dbg_state,     in_acc ? 32'd1 : (in_done ? 32'd2 : 32'd0));
      if (bus.ack0) begin ack_who.push_back(0); ack_at.push_back(cyc); end
      if (bus.ack1) begin ack_who.push_back(1); ack_at.push_back(cyc); end

      // Advance the model to the next cycle using what the next edge samples.
      if (in_acc) begin
         if (m_we) m_mem[m_addr] = m_wd;        // RAM commits even under reset
         else if (!rst) m_rd[m_who] = m_mem[m_addr];
      end
      if (rst) begin
         m_acc   = -1;
         m_ack   = -1;
         m_last  = 1;
         m_rd[0] = 8'h00;
         m_rd[1] = 8'h00;
      end else begin
         if (in_done) m_last = m_who;
         if (!in_acc && !in_done && (bus.req0 || bus.req1)) begin
            w      = pick_model(bus.req0, bus.req1, m_last);
            m_who  = w;
            m_we   = we_r[w];
            m_addr = addr_r[w];
            m_wd   = wd_r[w];
            m_acc  = cyc + 1;
            m_ack  = cyc + 2;
         end
      end
      cyc++;
   end

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
   task automatic do_op(input int n, input logic we, input logic [7:0] a,
                        input logic [7:0] d);
      int  t   = 0;
      bit  got = 1'b0;
      req_r[n]  = 1'b1;
      we_r[n]   = we;
      addr_r[n] = a;
      wd_r[n]   = d;
      while (!got && t < 100) begin
         @(negedge clk);
         got = (n == 1) ? bus.ack1 : bus.ack0;
         t++;
      end
      chk($sformatf("ack%0d_seen_addr%02h", n, a), 32'(got), 32'd1);
      @(posedge clk);
      #1;
      req_r[n] = 1'b0;
      we_r[n]  = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   int k0, k1, ones;

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_r[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = 8'h00; wd_r[i] = 8'h00;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy",   bus.busy,      32'd0);
      chk("rst_ack0",   bus.ack0,      32'd0);
      chk("rst_ack1",   bus.ack1,      32'd0);
      chk("rst_wr_en",  bus.ram_wr_en, 32'd0);
      chk("rst_abus",   bus.ram_abus,  32'd0);
      chk("rst_dbus_i", bus.ram_dbus_i, 32'd0);
      chk("rst_rdata0", bus.rdata0,    32'd0);
      chk("rst_rdata1", bus.rdata1,    32'd0);
      chk("rst_state",  dbg_state,     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single write by requester 1, then read back by requester 0
      req_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 8'h10; wd_r[1] = 8'hA5;
      @(negedge clk);
      chk("t1_idle_wr_en", bus.ram_wr_en, 32'd0);
      @(negedge clk);
      chk("t1_wr_en",   bus.ram_wr_en,  32'd1);
      chk("t1_abus",    bus.ram_abus,   32'h10);
      chk("t1_dbus_i",  bus.ram_dbus_i, 32'hA5);
      chk("t1_no_ack1", bus.ack1,       32'd0);
      @(negedge clk);
      chk("t1_ack1",       bus.ack1,      32'd1);
      chk("t1_done_wr_en", bus.ram_wr_en, 32'd0);
      @(posedge clk); #1;
      req_r[1] = 1'b0; we_r[1] = 1'b0;
      do_op(0, 1'b0, 8'h10, 8'h00);
      chk("t1_rdata0", bus.rdata0, 32'hA5);

      // Simultaneous reads, last grant was requester 0
      ack_who.delete(); ack_at.delete(); exp_q.delete();
      fork
         do_op(0, 1'b0, 8'h10, 8'h00);
         do_op(1, 1'b0, 8'h00, 8'h00);
      join
`ifdef RAM_ARB_RR_EN
      exp_q = '{8'd1, 8'd0};
`else
      exp_q = '{8'd0, 8'd1};
`endif
      chk("t2_n_acks", ack_who.size(), 32'd2);
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("t2_order%0d", i), (i < ack_who.size()) ? 32'(ack_who[i]) : 32'hFF, 32'(exp_q[i]));
      chk("t2_rdata0", bus.rdata0, 32'hA5);
      chk("t2_rdata1", bus.rdata1, 32'h00);

      // Lone request so the last grant is requester 1 in both builds
      do_op(1, 1'b0, 8'h10, 8'h00);
      chk("t3_pre_rdata1", bus.rdata1, 32'hA5);

      // Continuous traffic on both requesters
      ack_who.delete(); ack_at.delete(); exp_q.delete();
`ifdef RAM_ARB_RR_EN
      k0 = 4; k1 = 4;
      for (int i = 0; i < 8; i++) exp_q.push_back(8'(i % 2));
`else
      k0 = 8; k1 = 1;
      for (int i = 0; i < 8; i++) exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
`endif
      fork
         begin
            for (int i = 0; i < k0; i++) do_op(0, 1'b1, 8'(8'h40 + i), 8'(8'h50 + i));
         end
         begin
            for (int j = 0; j < k1; j++) do_op(1, 1'b0, 8'(8'h40 + j), 8'h00);
         end
      join
      chk("t3_n_acks", ack_who.size(), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("t3_order%0d", i), (i < ack_who.size()) ? 32'(ack_who[i]) : 32'hFF, 32'(exp_q[i]));
      for (int i = 1; i < ack_at.size(); i++)
         chk($sformatf("t3_spacing%0d", i), 32'(ack_at[i] - ack_at[i-1]), 32'd3);
      ones = 0;
      for (int i = 0; i < 8 && i < ack_who.size(); i++) ones += ack_who[i];
`ifdef RAM_ARB_RR_EN
      chk("t3_ack1_in_first8", 32'(ones), 32'd4);
`else
      chk("t3_ack1_in_first8", 32'(ones), 32'd0);
`endif

      // Top address write/read, address 0 untouched
      do_op(0, 1'b1, 8'hFF, 8'h3C);
      do_op(1, 1'b0, 8'hFF, 8'h00);
      chk("t4_rdata1_ff", bus.rdata1, 32'h3C);
      do_op(0, 1'b0, 8'h00, 8'h00);
      chk("t4_rdata0_00", bus.rdata0, 32'h00);

      // Reset during the ACCESS cycle of a write
      req_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 8'h20; wd_r[0] = 8'h77;
      @(posedge clk); #1;
      chk("t5_in_access_wr_en", bus.ram_wr_en, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_r[0] = 1'b0; we_r[0] = 1'b0;
      chk("t5_state",  dbg_state,   32'd0);
      chk("t5_busy",   bus.busy,    32'd0);
      chk("t5_ack0",   bus.ack0,    32'd0);
      chk("t5_rdata0", bus.rdata0,  32'd0);
      chk("t5_rdata1", bus.rdata1,  32'd0);
      do_op(1, 1'b0, 8'h20, 8'h00);
      chk("t5_rdata1_20", bus.rdata1, 32'h77);

      // Idle bus
      repeat (10) begin
         @(negedge clk);
         chk("t6_wr_en", bus.ram_wr_en, 32'd0);
         chk("t6_abus",  bus.ram_abus,  32'd0);
         chk("t6_busy",  bus.busy,      32'd0);
         chk("t6_ack0",  bus.ack0,      32'd0);
         chk("t6_ack1",  bus.ack1,      32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
